avs_ocmem_pipelined: RTL and testbench

AVS_OCMEM_PIPELINED -- requirements
Module: avs_ocmem_pipelined

---
 rtl/ocmem_pkg.sv | 16 +
 rtl/ocmem_array.sv | 42 ++++
 rtl/avs_ocmem_pipelined.sv | 185 ++++++++++++++++++
 tb/tb_avs_ocmem_pipelined.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocmem_pkg.sv
// Shared definitions for the pipelined on-chip memory slave.
//   fill_state_t       : fill engine state encoding (IDLE / DRAIN / FILL)
//   read_latency_legal : elaboration-time legality test for READ_LATENCY
package ocmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2
  } fill_state_t;

  function automatic bit read_latency_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/ocmem_array.sv
// Single-port synchronous RAM with byte-lane write enables.
// Read-first: a read and a write to the same word in the same cycle return
// the old contents. No reset; contents survive reset_n.
//   clk        : rising-edge clock
//   rd_en      : capture mem[address] into readdata on this edge
//   wr_en      : write enabled byte lanes of writedata to mem[address]
//   address    : word address
//   byteenable : per-byte write lanes
//   writedata  : write data
//   readdata   : registered read data, holds until the next rd_en
module ocmem_array #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 11,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Read-first port: the read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      readdata <= mem[address];
    end
    for (int b = 0; b < BE_W; b++) begin
      if (wr_en && byteenable[b]) begin
        mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/avs_ocmem_pipelined.sv
// Avalon-MM on-chip memory slave with a 1- or 2-stage read pipeline, write
// protection (debugaccess unlock unless WRITABLE), clock enable and a fill
// engine that overwrites the whole array with FILL_VALUE.
//   clk, reset_n                : clock, asynchronous active-low reset
//   address, byteenable         : word address, write byte lanes
//   chipselect, read, write     : Avalon command
//   writedata                   : write data
//   debugaccess                 : unlocks writes when WRITABLE == 0
//   clken                       : freezes pipeline and fill counter when low
//   reset_req                   : blocks command acceptance
//   fill_req                    : one-cycle pulse starting a fill
//   readdata, readdatavalid     : read response
//   waitrequest, fill_busy      : high while the fill engine owns the array
module avs_ocmem_pipelined
  import ocmem_pkg::*;
#(
  parameter int                 DATA_W       = 16,
  parameter int                 ADDR_W       = 11,
  parameter int                 READ_LATENCY = 1,
  parameter int                 WRITABLE     = 0,
  parameter string              INIT_FILE    = "",
  parameter logic [DATA_W-1:0]  FILL_VALUE   = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                debugaccess,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                fill_req,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                fill_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
      $error("avs_ocmem_pipelined: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  fill_state_t       state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              go, rd_acc, wr_acc, fill_we, in_flight, vld1;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_q;

  assign go      = chipselect & clken & ~reset_req & ~waitrequest;
  assign rd_acc  = go & read & ~write;
  assign wr_acc  = go & write & (debugaccess | (WRITABLE != 0));
  // Commands are blocked by waitrequest during FILL, so the fill owns the port.
  assign fill_we = (state == ST_FILL) & clken;

  assign ram_we    = fill_we | wr_acc;
  assign ram_addr  = fill_we ? cnt : address;
  assign ram_be    = fill_we ? {BE_W{1'b1}} : byteenable;
  assign ram_wdata = fill_we ? FILL_VALUE : writedata;

  ocmem_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk        (clk),
    .rd_en      (rd_acc),
    .wr_en      (ram_we),
    .address    (ram_addr),
    .byteenable (ram_be),
    .writedata  (ram_wdata),
    .readdata   (ram_q)
  );

  // First pipeline stage: marks that ram_q holds a freshly read word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld1 <= 1'b0;
    end else if (clken) begin
      vld1 <= rd_acc;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      logic loaded;

      // Gates the un-resettable RAM output so readdata reads as zero after reset.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          loaded <= 1'b0;
        end else if (rd_acc) begin
          loaded <= 1'b1;
        end
      end

      assign readdata      = loaded ? ram_q : {DATA_W{1'b0}};
      assign readdatavalid = vld1 & clken;
      assign in_flight     = vld1;
    end else begin : g_lat2
      logic              vld2;
      logic [DATA_W-1:0] data2;

      // Second pipeline stage: output register for the read word.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld2  <= 1'b0;
          data2 <= {DATA_W{1'b0}};
        end else if (clken) begin
          vld2 <= vld1;
          if (vld1) begin
            data2 <= ram_q;
          end
        end
      end

      assign readdata      = data2;
      assign readdatavalid = vld2 & clken;
      assign in_flight     = vld1 | vld2;
    end
  endgenerate

  // Fill engine state, counter and the status outputs derived from them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= {ADDR_W{1'b0}};
      waitrequest <= 1'b0;
      fill_busy   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      waitrequest <= (state_next != ST_IDLE);
      fill_busy   <= (state_next != ST_IDLE);
    end
  end

  // Fill engine next-state: wait for outstanding reads, then sweep the array.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (fill_req) begin
          state_next = ST_DRAIN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!in_flight) begin
          state_next = ST_FILL;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      ST_FILL: begin
        if (clken) begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state_next = ST_IDLE;
            cnt_next   = {ADDR_W{1'b0}};
          end else begin
            cnt_next = cnt + ADDR_W'(1);
          end
        end else begin
          cnt_next = cnt;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = {ADDR_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_avs_ocmem_pipelined.sv
// Self-checking bench: two instances (READ_LATENCY 1 and 2, 16 words, 16-bit)
// share the same stimulus; a transaction-level model predicts their outputs.
module tb_avs_ocmem_pipelined;

  localparam logic [15:0] FV = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset_n, chipselect, read, write, debugaccess, clken, reset_req, fill_req;
  logic [3:0]  address;
  logic [1:0]  byteenable;
  logic [15:0] writedata;
  logic [15:0] rdata [2];
  logic        rdv [2];
  logic        wreq [2];
  logic        fbusy [2];

  always #5 clk = ~clk;

  avs_ocmem_pipelined #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(1), .WRITABLE(0),
                        .INIT_FILE(""), .FILL_VALUE(FV)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .debugaccess(debugaccess), .clken(clken), .reset_req(reset_req), .fill_req(fill_req),
    .readdata(rdata[0]), .readdatavalid(rdv[0]), .waitrequest(wreq[0]), .fill_busy(fbusy[0]));

  avs_ocmem_pipelined #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(2), .WRITABLE(0),
                        .INIT_FILE(""), .FILL_VALUE(FV)) u_dut_l2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .debugaccess(debugaccess), .clken(clken), .reset_req(reset_req), .fill_req(fill_req),
    .readdata(rdata[1]), .readdatavalid(rdv[1]), .waitrequest(wreq[1]), .fill_busy(fbusy[1]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: memory image, outstanding reads (data + enabled-edge stamp),
  // fill phase (0 idle, 1 drain, 2 fill) and counter, last delivered word.
  logic [15:0] mem_m [2][16];
  logic [15:0] dq [2][$];
  int          sq [2][$];
  int          ph [2];
  int          fcnt [2];
  logic [15:0] last_m [2];
  int          en_cnt = 0;
  bit          chk_en = 1'b0;
  int          rdv_cnt [2];
  int          busy_cnt [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      rdv_cnt[k] = 0;
      busy_cnt[k] = 0;
    end
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int k = 0; k < 2; k++) begin
          dq[k].delete();
          sq[k].delete();
          ph[k] = 0;
          fcnt[k] = 0;
          last_m[k] = 16'h0000;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          bit inflight, go;
          inflight = dq[k].size() != 0;
          // A word delivered this cycle (latency k+1) is consumed on an enabled edge.
          if (clken && inflight && (en_cnt - sq[k][0]) == k) begin
            last_m[k] = dq[k].pop_front();
            void'(sq[k].pop_front());
          end
          go = chipselect && clken && !reset_req && (ph[k] == 0);
          if (go && read && !write) begin
            dq[k].push_back(mem_m[k][address]);
            sq[k].push_back(en_cnt + 1);
          end
          if (go && write && debugaccess) begin
            for (int b = 0; b < 2; b++)
              if (byteenable[b]) mem_m[k][address][b*8 +: 8] = writedata[b*8 +: 8];
          end
          case (ph[k])
            0: if (fill_req) ph[k] = 1;
            1: if (!inflight) ph[k] = 2;
            2: if (clken) begin
                 mem_m[k][fcnt[k]] = FV;
                 if (fcnt[k] == 15) begin
                   ph[k] = 0;
                   fcnt[k] = 0;
                 end else begin
                   fcnt[k]++;
                 end
               end
            default: ph[k] = 0;
          endcase
        end
        if (clken) en_cnt++;
      end
    end
  end

  // Output checker, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rdv[k] === 1'b1) rdv_cnt[k]++;
        if (fbusy[k] === 1'b1) busy_cnt[k]++;
        if (reset_n && chk_en) begin
          bit at_out;
          logic [15:0] exp_d;
          at_out = dq[k].size() != 0 && (en_cnt - sq[k][0]) == k;
          exp_d  = at_out ? dq[k][0] : last_m[k];
          check_eq($sformatf("rdv_l%0d", k + 1), 32'(rdv[k]), 32'(at_out && clken));
          check_eq($sformatf("rdata_l%0d", k + 1), 32'(rdata[k]), 32'(exp_d));
          check_eq($sformatf("waitreq_l%0d", k + 1), 32'(wreq[k]), 32'(ph[k] != 0));
          check_eq($sformatf("fill_busy_l%0d", k + 1), 32'(fbusy[k]), 32'(ph[k] != 0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    fill_req   = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be,
                          input logic dbg);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be; debugaccess = dbg;
    tick();
    idle_inputs();
  endtask

  task automatic do_read(input logic [3:0] a);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    tick();
    idle_inputs();
  endtask

  task automatic read_expect(input string tag, input logic [3:0] a, input logic [15:0] exp);
    do_read(a);
    repeat (3) tick();
    check_eq({tag, "_l1"}, 32'(rdata[0]), 32'(exp));
    check_eq({tag, "_l2"}, 32'(rdata[1]), 32'(exp));
  endtask

  task automatic wait_fill_done(input string tag);
    int n;
    n = 0;
    while ((fbusy[0] !== 1'b0 || fbusy[1] !== 1'b0) && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(fbusy[0] | fbusy[1]), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_rdata_l%0d", tag, k + 1), 32'(rdata[k]), 32'd0);
      check_eq($sformatf("%s_rdv_l%0d", tag, k + 1), 32'(rdv[k]), 32'd0);
      check_eq($sformatf("%s_wreq_l%0d", tag, k + 1), 32'(wreq[k]), 32'd0);
      check_eq($sformatf("%s_busy_l%0d", tag, k + 1), 32'(fbusy[k]), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int snap [2];
    int n;
    reset_n = 1'b0;
    idle_inputs();
    debugaccess = 1'b0; clken = 1'b1; reset_req = 1'b0;
    address = 4'd0; byteenable = 2'b00; writedata = 16'h0000;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Define the whole array first.
    fill_req = 1'b1; tick(); fill_req = 1'b0;
    wait_fill_done("fill0_done");

    // Write then read back; protection; byte lanes.
    do_write(4'd5, 16'hBEEF, 2'b11, 1'b1);
    read_expect("wr_rd", 4'd5, 16'hBEEF);
    do_write(4'd5, 16'h1234, 2'b11, 1'b0);
    read_expect("protect", 4'd5, 16'hBEEF);
    do_write(4'd5, 16'h1234, 2'b01, 1'b1);
    read_expect("byte_lane", 4'd5, 16'hBE34);

    // Back-to-back reads with a 3-cycle clken stall in the middle.
    for (int k = 0; k < 2; k++) snap[k] = rdv_cnt[k];
    chipselect = 1'b1; read = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 4'(a);
      if (a == 2) begin
        clken = 1'b0;
        repeat (3) tick();
        clken = 1'b1;
      end
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    for (int k = 0; k < 2; k++)
      check_eq($sformatf("burst_count_l%0d", k + 1), 32'(rdv_cnt[k] - snap[k]), 32'd4);

    // Fill requested with a read in flight: drain, then 16 fill cycles.
    do_read(4'd7);
    for (int k = 0; k < 2; k++) snap[k] = busy_cnt[k];
    fill_req = 1'b1; tick(); fill_req = 1'b0;
    wait_fill_done("fill1_done");
    check_eq("busy_cycles_l1", 32'(busy_cnt[0] - snap[0]), 32'd17);
    check_eq("busy_cycles_l2", 32'(busy_cnt[1] - snap[1]), 32'd18);
    read_expect("fill_9", 4'd9, FV);
    read_expect("fill_0", 4'd0, FV);

    // Distinct pattern, then a fill abandoned by reset at fill cycle 7.
    for (int a = 0; a < 16; a++) do_write(4'(a), 16'h1000 + 16'(a), 2'b11, 1'b1);
    repeat (2) tick();
    fill_req = 1'b1; tick(); fill_req = 1'b0;
    n = 0;
    while (!(ph[0] == 2 && fcnt[0] == 7) && n < 50) begin
      tick();
      n++;
    end
    check_eq("reach_fill7", 32'(fbusy[0] & fbusy[1]), 32'd1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_fill_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    read_expect("partial_6", 4'd6, FV);
    read_expect("partial_7", 4'd7, 16'h1007);
    for (int a = 0; a < 16; a++) do_read(4'(a));
    repeat (4) tick();

    // Random traffic against the model.
    repeat (400) begin
      chipselect  = ($urandom_range(0, 3) != 0);
      read        = $urandom_range(0, 1) == 1;
      write       = $urandom_range(0, 2) == 0;
      address     = 4'($urandom_range(0, 15));
      byteenable  = 2'($urandom_range(0, 3));
      writedata   = 16'($urandom);
      debugaccess = $urandom_range(0, 1) == 1;
      clken       = ($urandom_range(0, 6) != 0);
      reset_req   = ($urandom_range(0, 9) == 0);
      fill_req    = ($urandom_range(0, 149) == 0);
      tick();
    end
    idle_inputs();
    clken = 1'b1;
    reset_req = 1'b0;
    wait_fill_done("final_idle");
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
